// File: rtl/fft_bitrev_if.sv
// Stream bundle for fft_bitrev: bit-reversed samples in, natural-order samples out.
// The slave modport is the reorder block; the master modport is the surrounding fabric.
interface fft_bitrev_if #(
    parameter int WIDTH = 25
);
    logic                    valid_i;
    logic                    sof_i;
    logic signed [WIDTH-1:0] x_re_i;
    logic signed [WIDTH-1:0] x_im_i;
    logic                    ready_i;
    logic                    valid_o;
    logic                    sof_o;
    logic                    last_o;
    logic signed [WIDTH-1:0] z_re_o;
    logic signed [WIDTH-1:0] z_im_o;
    logic                    overflow_o;
    logic [15:0]             drop_cnt_o;

    modport slave (
        input  valid_i, sof_i, x_re_i, x_im_i, ready_i,
        output valid_o, sof_o, last_o, z_re_o, z_im_o, overflow_o, drop_cnt_o
    );

    modport master (
        output valid_i, sof_i, x_re_i, x_im_i, ready_i,
        input  valid_o, sof_o, last_o, z_re_o, z_im_o, overflow_o, drop_cnt_o
    );
endinterface

// File: rtl/fft_bitrev.sv
// Bit-reversal reorder buffer: ping-pong banks written at bitrev(k), drained in natural order.
// Define FFT_BITREV_DROP_CNT_EN to enable the saturating dropped-frame counter on drop_cnt_o.
module fft_bitrev #(
    parameter int WIDTH  = 25,
    parameter int N_LOG2 = 10
) (
    input logic         clk,
    input logic         rst_n,
    fft_bitrev_if.slave bus
);
    localparam int N = 1 << N_LOG2;

    localparam logic [1:0] ST_EMPTY    = 2'd0;
    localparam logic [1:0] ST_FILLING  = 2'd1;
    localparam logic [1:0] ST_FULL     = 2'd2;
    localparam logic [1:0] ST_DRAINING = 2'd3;

    typedef logic [N_LOG2-1:0] idx_t;
    localparam idx_t IDX_LAST = idx_t'(N - 1);

    function automatic idx_t bitrev(input idx_t k);
        idx_t r;
        r = '0;
        for (int b = 0; b < N_LOG2; b++) r[b] = k[N_LOG2-1-b];
        return r;
    endfunction

    logic [1:0]              bank_st_q [2];
    logic [1:0]              bank_st_d [2];
    logic                    wr_bank_q, wr_bank_d;
    logic                    wr_active_q, wr_active_d;
    idx_t                    wr_cnt_q, wr_cnt_d;
    logic                    rd_bank_q, rd_bank_d;
    idx_t                    rd_cnt_q, rd_cnt_d;
    logic                    out_bank_q, out_bank_d;
    logic                    valid_o_q, valid_o_d;
    logic                    sof_o_q, sof_o_d;
    logic                    last_o_q, last_o_d;
    logic                    ovf_q, ovf_d;
    logic signed [WIDTH-1:0] z_re_q, z_re_d;
    logic signed [WIDTH-1:0] z_im_q, z_im_d;

    logic signed [WIDTH-1:0] mem_re [2*N];
    logic signed [WIDTH-1:0] mem_im [2*N];
    logic                    wr_en;
    logic [N_LOG2:0]         wr_addr;
    logic [N_LOG2:0]         rd_addr;
    logic                    pop;
    logic                    rd_avail;

    assign rd_addr = {rd_bank_q, rd_cnt_q};

    always_comb begin
        // NOTE: every *_d starts from its _q value so no branch can leave a latch behind.
        bank_st_d   = bank_st_q;
        wr_bank_d   = wr_bank_q;
        wr_active_d = wr_active_q;
        wr_cnt_d    = wr_cnt_q;
        rd_bank_d   = rd_bank_q;
        rd_cnt_d    = rd_cnt_q;
        out_bank_d  = out_bank_q;
        valid_o_d   = valid_o_q;
        sof_o_d     = sof_o_q;
        last_o_d    = last_o_q;
        z_re_d      = z_re_q;
        z_im_d      = z_im_q;
        ovf_d       = 1'b0;
        wr_en       = 1'b0;
        wr_addr     = {wr_bank_q, bitrev(wr_cnt_q)};
        pop         = valid_o_q & bus.ready_i;
        rd_avail    = (rd_cnt_q != '0) || (bank_st_q[rd_bank_q] == ST_FULL);

        // Retiring the last sample frees its bank before the write side looks at it.
        if (pop) begin
            valid_o_d = 1'b0;
            if (last_o_q) bank_st_d[out_bank_q] = ST_EMPTY;
        end

        if ((!valid_o_q || bus.ready_i) && rd_avail) begin
            valid_o_d  = 1'b1;
            sof_o_d    = (rd_cnt_q == '0);
            last_o_d   = (rd_cnt_q == IDX_LAST);
            z_re_d     = mem_re[rd_addr];
            z_im_d     = mem_im[rd_addr];
            out_bank_d = rd_bank_q;
            rd_cnt_d   = rd_cnt_q + idx_t'(1);
            if (rd_cnt_q == '0) bank_st_d[rd_bank_q] = ST_DRAINING;
            if (rd_cnt_q == IDX_LAST) rd_bank_d = ~rd_bank_q;
        end

        if (bus.valid_i && bus.sof_i) begin
            // A restart mid-frame abandons the partial frame; the new one may reuse the bank at once.
            if (wr_active_q) begin
                bank_st_d[wr_bank_q] = ST_EMPTY;
                ovf_d                = 1'b1;
            end
            if (bank_st_d[wr_bank_q] == ST_EMPTY) begin
                wr_en                = 1'b1;
                wr_addr              = {wr_bank_q, {N_LOG2{1'b0}}};
                bank_st_d[wr_bank_q] = ST_FILLING;
                wr_active_d          = 1'b1;
                wr_cnt_d             = idx_t'(1);
            end else begin
                ovf_d       = 1'b1;
                wr_active_d = 1'b0;
                wr_cnt_d    = '0;
            end
        end else if (bus.valid_i && wr_active_q) begin
            wr_en = 1'b1;
            if (wr_cnt_q == IDX_LAST) begin
                bank_st_d[wr_bank_q] = ST_FULL;
                wr_bank_d            = ~wr_bank_q;
                wr_active_d          = 1'b0;
                wr_cnt_d             = '0;
            end else begin
                wr_cnt_d = wr_cnt_q + idx_t'(1);
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bank_st_q[0] <= ST_EMPTY;
            bank_st_q[1] <= ST_EMPTY;
            wr_bank_q    <= 1'b0;
            wr_active_q  <= 1'b0;
            wr_cnt_q     <= '0;
            rd_bank_q    <= 1'b0;
            rd_cnt_q     <= '0;
            out_bank_q   <= 1'b0;
            valid_o_q    <= 1'b0;
            sof_o_q      <= 1'b0;
            last_o_q     <= 1'b0;
            ovf_q        <= 1'b0;
            z_re_q       <= '0;
            z_im_q       <= '0;
        end else begin
            bank_st_q    <= bank_st_d;
            wr_bank_q    <= wr_bank_d;
            wr_active_q  <= wr_active_d;
            wr_cnt_q     <= wr_cnt_d;
            rd_bank_q    <= rd_bank_d;
            rd_cnt_q     <= rd_cnt_d;
            out_bank_q   <= out_bank_d;
            valid_o_q    <= valid_o_d;
            sof_o_q      <= sof_o_d;
            last_o_q     <= last_o_d;
            ovf_q        <= ovf_d;
            z_re_q       <= z_re_d;
            z_im_q       <= z_im_d;
        end
    end

    // NOTE: the sample memory has no reset; a bank is only read after all its addresses were written.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_re[wr_addr] <= bus.x_re_i;
            mem_im[wr_addr] <= bus.x_im_i;
        end
    end

`ifdef FFT_BITREV_DROP_CNT_EN
    logic [15:0] drop_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt_q <= 16'h0000;
        end else if (ovf_d && (drop_cnt_q != 16'hFFFF)) begin
            drop_cnt_q <= drop_cnt_q + 16'd1;
        end
    end

    assign bus.drop_cnt_o = drop_cnt_q;
`else
    assign bus.drop_cnt_o = 16'h0000;
`endif

    assign bus.valid_o    = valid_o_q;
    assign bus.sof_o      = sof_o_q;
    assign bus.last_o     = last_o_q;
    assign bus.z_re_o     = z_re_q;
    assign bus.z_im_o     = z_im_q;
    assign bus.overflow_o = ovf_q;
endmodule
